// File: rtl/and_ff_arbiter_if.sv
// Requester-side bus of the and_ff arbiter.
// Carries req/a/b in, grant and response strobes back.
interface and_ff_arbiter_if #(
  parameter int NUM_REQ = 4
) ();

  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] req_a;
  logic [NUM_REQ-1:0] req_b;
  logic [NUM_REQ-1:0] gnt;
  logic [NUM_REQ-1:0] rsp_valid;
  logic               rsp_z;

  modport master (
    output req,
    output req_a,
    output req_b,
    input  gnt,
    input  rsp_valid,
    input  rsp_z
  );

  modport slave (
    input  req,
    input  req_a,
    input  req_b,
    output gnt,
    output rsp_valid,
    output rsp_z
  );

endinterface

// File: rtl/and_ff_arbiter.sv
// Round-robin arbiter sharing one and_ff datapath.
// Ports: clk, rst_n, bus (slave), busy, txn_count, ff_enable/a/b out, ff_z in.
module and_ff_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  and_ff_arbiter_if.slave     bus,
  output logic                busy,
  output logic [7:0]          txn_count,
  output logic                ff_enable,
  output logic                ff_a,
  output logic                ff_b,
  input  logic                ff_z
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    CAPTURE,
    RESP
  } state_t;

  state_t             state;
  logic [IW-1:0]      id_q;
  logic [IW-1:0]      ptr;
  logic [NUM_REQ-1:0] gnt_q;
  logic [NUM_REQ-1:0] vld_q;
  logic               z_q;

  logic [IW-1:0]      pick;
  logic [IW:0]        idx;
  logic               found;

  function automatic logic [IW:0] wrap(
    input logic [IW:0] v
  );
    if (v >= (IW+1)'(NUM_REQ))
      return v - (IW+1)'(NUM_REQ);
    return v;
  endfunction

  function automatic logic [IW-1:0] inc(
    input logic [IW-1:0] v
  );
    logic [IW:0] s;
    s = wrap({1'b0, v} + (IW+1)'(1));
    return s[IW-1:0];
  endfunction

  function automatic logic [NUM_REQ-1:0] onehot(
    input logic [IW-1:0] v
  );
    return NUM_REQ'(1) << v;
  endfunction

  // Scan upward from ptr; first requester found wins.
  always_comb begin
    pick  = '0;
    idx   = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = wrap({1'b0, ptr} + (IW+1)'(i));
      if (!found && bus.req[idx[IW-1:0]]) begin
        found = 1'b1;
        pick  = idx[IW-1:0];
      end
    end
  end

  // ff_a/ff_b double as the latched operands and
  // hold their value outside ISSUE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      id_q      <= '0;
      ptr       <= '0;
      gnt_q     <= '0;
      vld_q     <= '0;
      z_q       <= 1'b0;
      busy      <= 1'b0;
      txn_count <= '0;
      ff_enable <= 1'b0;
      ff_a      <= 1'b0;
      ff_b      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (found) begin
            id_q      <= pick;
            ptr       <= inc(pick);
            gnt_q     <= onehot(pick);
            ff_a      <= bus.req_a[pick];
            ff_b      <= bus.req_b[pick];
            ff_enable <= 1'b1;
            busy      <= 1'b1;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          gnt_q     <= '0;
          ff_enable <= 1'b0;
          state     <= CAPTURE;
        end
        CAPTURE: begin
          z_q   <= ff_z;
          vld_q <= onehot(id_q);
          state <= RESP;
        end
        RESP: begin
          vld_q     <= '0;
          z_q       <= 1'b0;
          busy      <= 1'b0;
          txn_count <= txn_count + 8'd1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.rsp_valid = vld_q;
  assign bus.rsp_z     = z_q;

endmodule

// File: tb/tb_and_ff_arbiter.sv
// Directed bench for and_ff_arbiter with a behavioural and_ff.
// Scenario tasks check outputs inline and tally total/bad.
module tb_and_ff_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       busy;
  logic [7:0] txn_count;
  logic       ff_enable;
  logic       ff_a;
  logic       ff_b;
  logic       ff_z;

  int         total = 0;
  int         bad = 0;
  logic [7:0] exp_cnt = 8'd0;

  and_ff_arbiter_if #(.NUM_REQ(4)) bus ();

  and_ff_arbiter #(.NUM_REQ(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .busy      (busy),
    .txn_count (txn_count),
    .ff_enable (ff_enable),
    .ff_a      (ff_a),
    .ff_b      (ff_b),
    .ff_z      (ff_z)
  );

  always #5 clk = ~clk;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      ff_z <= 1'b0;
    else if (ff_enable)
      ff_z <= ff_a & ff_b;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    bus.req   = 4'b0;
    bus.req_a = 4'b0;
    bus.req_b = 4'b0;
    rst_n     = 1'b0;
    tick();
    tick();
    rst_n   = 1'b1;
    exp_cnt = 8'd0;
  endtask

  task automatic test_reset;
    bus.req   = 4'b0;
    bus.req_a = 4'b0;
    bus.req_b = 4'b0;
    rst_n     = 1'b0;
    tick();
    total++;
    if ({bus.gnt, bus.rsp_valid} !== 8'h00) begin
      bad++;
      $display("FAIL reset_gnt_vld got=%h want=00",
               {bus.gnt, bus.rsp_valid});
    end
    total++;
    if ({bus.rsp_z, busy, ff_enable, ff_a, ff_b} !== 5'b0) begin
      bad++;
      $display("FAIL reset_bits got=%b want=00000",
               {bus.rsp_z, busy, ff_enable, ff_a, ff_b});
    end
    total++;
    if (txn_count !== 8'd0) begin
      bad++;
      $display("FAIL reset_cnt got=%0d want=0", txn_count);
    end
    rst_n = 1'b1;
    tick();
    total++;
    if ({busy, bus.gnt} !== 5'b0) begin
      bad++;
      $display("FAIL idle_noreq got=%b want=00000",
               {busy, bus.gnt});
    end
  endtask

  task automatic test_single;
    bus.req   = 4'b0001;
    bus.req_a = 4'b0001;
    bus.req_b = 4'b0001;
    tick();
    total++;
    if ({bus.gnt, ff_enable, busy} !== 6'b0001_1_1) begin
      bad++;
      $display("FAIL single_issue got=%b want=000111",
               {bus.gnt, ff_enable, busy});
    end
    bus.req = 4'b0;
    tick();
    total++;
    if ({bus.gnt, ff_enable, bus.rsp_valid} !== 9'b0) begin
      bad++;
      $display("FAIL single_capture got=%b want=0",
               {bus.gnt, ff_enable, bus.rsp_valid});
    end
    tick();
    total++;
    if ({bus.rsp_valid, bus.rsp_z} !== 5'b0001_1) begin
      bad++;
      $display("FAIL single_resp got=%b want=00011",
               {bus.rsp_valid, bus.rsp_z});
    end
    tick();
    exp_cnt++;
    total++;
    if (txn_count !== exp_cnt || busy !== 1'b0) begin
      bad++;
      $display("FAIL single_cnt got=%0d/%b want=%0d/0",
               txn_count, busy, exp_cnt);
    end
    total++;
    if (bus.rsp_valid !== 4'b0) begin
      bad++;
      $display("FAIL single_vld_drop got=%b want=0000",
               bus.rsp_valid);
    end
  endtask

  task automatic test_truth;
    logic [3:0] zt;
    zt = 4'b1000;
    for (int k = 0; k < 4; k++) begin
      bus.req   = 4'b0100;
      bus.req_a = {1'b0, k[1], 2'b0};
      bus.req_b = {1'b0, k[0], 2'b0};
      tick();
      total++;
      if (bus.gnt !== 4'b0100) begin
        bad++;
        $display("FAIL truth_gnt%0d got=%b want=0100",
                 k, bus.gnt);
      end
      bus.req = 4'b0;
      tick();
      tick();
      total++;
      if (bus.rsp_valid !== 4'b0100 ||
          bus.rsp_z !== zt[k]) begin
        bad++;
        $display("FAIL truth_z%0d got=%b/%b want=0100/%b",
                 k, bus.rsp_valid, bus.rsp_z, zt[k]);
      end
      tick();
      exp_cnt++;
      total++;
      if (txn_count !== exp_cnt) begin
        bad++;
        $display("FAIL truth_cnt%0d got=%0d want=%0d",
                 k, txn_count, exp_cnt);
      end
    end
  endtask

  task automatic test_fairness;
    logic [3:0] oh;
    do_reset();
    bus.req   = 4'b1111;
    bus.req_a = 4'b1111;
    bus.req_b = 4'b1111;
    for (int t = 0; t < 8; t++) begin
      oh = 4'b0001 << (t % 4);
      tick();
      total++;
      if (bus.gnt !== oh || busy !== 1'b1) begin
        bad++;
        $display("FAIL fair_gnt%0d got=%b/%b want=%b/1",
                 t, bus.gnt, busy, oh);
      end
      tick();
      total++;
      if (busy !== 1'b1) begin
        bad++;
        $display("FAIL fair_busy%0d got=%b want=1", t, busy);
      end
      tick();
      total++;
      if (bus.rsp_valid !== oh || bus.rsp_z !== 1'b1) begin
        bad++;
        $display("FAIL fair_rsp%0d got=%b/%b want=%b/1",
                 t, bus.rsp_valid, bus.rsp_z, oh);
      end
      tick();
      if (t == 7)
        bus.req = 4'b0;
      total++;
      if (busy !== 1'b0 || bus.gnt !== 4'b0) begin
        bad++;
        $display("FAIL fair_idle%0d got=%b/%b want=0/0000",
                 t, busy, bus.gnt);
      end
    end
    exp_cnt = 8'd8;
    tick();
    total++;
    if (txn_count !== exp_cnt || busy !== 1'b0) begin
      bad++;
      $display("FAIL fair_cnt got=%0d/%b want=8/0",
               txn_count, busy);
    end
  endtask

  task automatic test_hold;
    logic [3:0] a0;
    logic [3:0] b0;
    logic       ez;
    for (int v = 0; v < 2; v++) begin
      a0 = 4'b0010;
      b0 = (v == 0) ? 4'b0010 : 4'b0000;
      ez = (v == 0);
      bus.req   = 4'b0010;
      bus.req_a = a0;
      bus.req_b = b0;
      tick();
      total++;
      if (bus.gnt !== 4'b0010) begin
        bad++;
        $display("FAIL hold_gnt%0d got=%b want=0010",
                 v, bus.gnt);
      end
      bus.req   = 4'b0;
      bus.req_a = ~a0;
      bus.req_b = ~b0;
      tick();
      bus.req_a = a0 ^ 4'b0010;
      bus.req_b = 4'b0010;
      total++;
      if (ff_a !== a0[1] || ff_b !== b0[1]) begin
        bad++;
        $display("FAIL hold_ff%0d got=%b%b want=%b%b",
                 v, ff_a, ff_b, a0[1], b0[1]);
      end
      tick();
      total++;
      if (bus.rsp_valid !== 4'b0010 || bus.rsp_z !== ez) begin
        bad++;
        $display("FAIL hold_z%0d got=%b/%b want=0010/%b",
                 v, bus.rsp_valid, bus.rsp_z, ez);
      end
      tick();
      exp_cnt++;
    end
    total++;
    if (txn_count !== exp_cnt) begin
      bad++;
      $display("FAIL hold_cnt got=%0d want=%0d",
               txn_count, exp_cnt);
    end
  endtask

  task automatic test_midreset;
    bus.req   = 4'b0100;
    bus.req_a = 4'b0100;
    bus.req_b = 4'b0100;
    tick();
    bus.req = 4'b0;
    tick();
    total++;
    if (ff_a !== 1'b1 || busy !== 1'b1) begin
      bad++;
      $display("FAIL mid_pre got=%b%b want=11", ff_a, busy);
    end
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if ({bus.gnt, bus.rsp_valid, bus.rsp_z, busy,
         ff_enable, ff_a, ff_b, txn_count} !== 21'b0) begin
      bad++;
      $display("FAIL mid_async got=%b cnt=%0d want=0",
               {bus.gnt, bus.rsp_valid, bus.rsp_z, busy,
                ff_enable, ff_a, ff_b}, txn_count);
    end
    #1;
    rst_n     = 1'b1;
    exp_cnt   = 8'd0;
    bus.req   = 4'b1010;
    bus.req_a = 4'b0010;
    bus.req_b = 4'b0010;
    tick();
    total++;
    if (bus.gnt !== 4'b0010 || bus.rsp_valid !== 4'b0) begin
      bad++;
      $display("FAIL mid_regnt got=%b/%b want=0010/0000",
               bus.gnt, bus.rsp_valid);
    end
    total++;
    if (txn_count !== 8'd0) begin
      bad++;
      $display("FAIL mid_cnt got=%0d want=0", txn_count);
    end
    bus.req = 4'b0;
    tick();
    tick();
    total++;
    if (bus.rsp_valid !== 4'b0010 || bus.rsp_z !== 1'b1) begin
      bad++;
      $display("FAIL mid_rsp got=%b/%b want=0010/1",
               bus.rsp_valid, bus.rsp_z);
    end
    tick();
  endtask

  task automatic test_wrap;
    int   pulses;
    logic saw;
    pulses = 0;
    saw    = 1'b0;
    do_reset();
    bus.req   = 4'b0001;
    bus.req_a = 4'b0001;
    bus.req_b = 4'b0000;
    for (int t = 0; t < 256; t++) begin
      tick();
      tick();
      tick();
      if (bus.rsp_valid === 4'b0001)
        pulses++;
      tick();
      if (t == 255)
        bus.req = 4'b0;
      if (exp_cnt == 8'd255 && txn_count === 8'd0)
        saw = 1'b1;
      exp_cnt++;
      total++;
      if (txn_count !== exp_cnt) begin
        bad++;
        $display("FAIL wrap_cnt%0d got=%0d want=%0d",
                 t, txn_count, exp_cnt);
      end
    end
    total++;
    if (pulses != 256) begin
      bad++;
      $display("FAIL wrap_pulses got=%0d want=256", pulses);
    end
    total++;
    if (saw !== 1'b1 || txn_count !== 8'd0) begin
      bad++;
      $display("FAIL wrap_edge got=%b/%0d want=1/0",
               saw, txn_count);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_truth();
    test_fairness();
    test_hold();
    test_midreset();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
